// File: rtl/batch_dispatcher.sv
// Issue-side dispatcher: packs instructions into per-unit batch lanes, tags the
// last batch of a program, then waits for every functional unit to report done.
module batch_dispatcher #(
  parameter int NUM_FU            = 4,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int FORMAT_WIDTH      = 2,
  parameter int METADATA_WIDTH    = 1 + FORMAT_WIDTH,
  parameter int BATCH_WIDTH       = METADATA_WIDTH + INSTRUCTION_WIDTH,
  parameter int DRAIN_TIMEOUT     = 64,
  parameter int FU_SEL_W          = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           inValid,
  output logic                           inReady,
  input  logic [INSTRUCTION_WIDTH-1:0]   inInstr,
  input  logic [FORMAT_WIDTH-1:0]        inFormat,
  input  logic [FU_SEL_W-1:0]            inFu,
  input  logic                           inLast,
  output logic [NUM_FU*BATCH_WIDTH-1:0]  batch,
  output logic                           endTag,
  input  logic [NUM_FU-1:0]              doneBatches,
  output logic                           busy,
  output logic                           done,
  output logic                           timeoutErr,
  output logic [15:0]                    issuedCount
);

  localparam int CNT_W = $clog2(DRAIN_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                          r_state;
  logic [NUM_FU-1:0]               r_flags;
  logic [CNT_W-1:0]                r_drain_cnt;
  logic [NUM_FU*BATCH_WIDTH-1:0]   r_batch;
  logic                            r_end_tag;
  logic                            r_busy;
  logic                            r_done;
  logic                            r_timeout_err;
  logic [15:0]                     r_issued;

  logic                            w_accept;
  logic [NUM_FU-1:0]               w_flags_next;
  logic [BATCH_WIDTH-1:0]          w_lane;
  logic [NUM_FU*BATCH_WIDTH-1:0]   w_batch_next;

  assign inReady      = (r_state == S_ISSUE);
  assign w_accept     = inValid && inReady;
  assign w_flags_next = r_flags | doneBatches;

  // Out-of-range unit selects match no lane, so those instructions become bubbles.
  always_comb begin
    w_lane = '0;
    w_lane[METADATA_WIDTH +: INSTRUCTION_WIDTH] = inInstr;
    w_lane[1 +: FORMAT_WIDTH] = inFormat;
    w_lane[0] = 1'b1;
    w_batch_next = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (w_accept && (inFu == FU_SEL_W'(i))) begin
        w_batch_next[i*BATCH_WIDTH +: BATCH_WIDTH] = w_lane;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_flags       <= '0;
      r_drain_cnt   <= '0;
      r_batch       <= '0;
      r_end_tag     <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_issued      <= 16'd0;
    end else begin
      r_batch   <= w_batch_next;
      r_end_tag <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state       <= S_ISSUE;
            r_busy        <= 1'b1;
            r_issued      <= 16'd0;
            r_timeout_err <= 1'b0;
            r_flags       <= '0;
          end
        end
        S_ISSUE: begin
          if (w_accept) begin
            if (r_issued != 16'hFFFF) begin
              r_issued <= r_issued + 16'd1;
            end
            if (inLast) begin
              r_end_tag   <= 1'b1;
              r_state     <= S_DRAIN;
              r_drain_cnt <= '0;
            end
          end
        end
        S_DRAIN: begin
          // Completion uses this cycle's doneBatches, not just the stored flags.
          r_flags     <= w_flags_next;
          r_drain_cnt <= r_drain_cnt + CNT_W'(1);
          if (&w_flags_next) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (r_drain_cnt == CNT_LAST) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_DONE;
            r_done        <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign batch       = r_batch;
  assign endTag      = r_end_tag;
  assign busy        = r_busy;
  assign done        = r_done;
  assign timeoutErr  = r_timeout_err;
  assign issuedCount = r_issued;

endmodule
